// File: rtl/divider_speed_arbiter_if.sv
// Request/grant bundle between speed requesters and the shared divider arbiter.
// The arbiter takes the slave side; the requesters and the divider take the master side.
interface divider_speed_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int SPEED_W = 20
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*SPEED_W-1:0] reqSpeed;
    logic [NUM_REQ-1:0]         ack;
    logic [NUM_REQ-1:0]         err;
    logic [ID_W-1:0]            grantId;
    logic                       grantValid;
    logic [SPEED_W-1:0]         divSpeed;
    logic                       divReset;
    logic                       busy;

    modport master (
        output req, reqSpeed,
        input  ack, err, grantId, grantValid, divSpeed, divReset, busy
    );

    modport slave (
        input  req, reqSpeed,
        output ack, err, grantId, grantValid, divSpeed, divReset, busy
    );
endinterface

// File: rtl/divider_speed_arbiter.sv
// Round-robin owner of one programmable clock divider: load, reset strobe, dwell.
// Define DIV_ARB_CLAMP_EN to clamp nonzero requested speeds to [MIN_SPEED, MAX_SPEED].
module divider_speed_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int SPEED_W       = 20,
    parameter int HOLD_CYCLES   = 1024,
    parameter int DEFAULT_SPEED = 1000,
    parameter int MIN_SPEED     = 1,
    parameter int MAX_SPEED     = 1000000
) (
    input  logic                   inClock,
    input  logic                   reset,
    divider_speed_arbiter_if.slave bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IX_W  = ID_W + 1;
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [SPEED_W-1:0] SPD_RST   = SPEED_W'(DEFAULT_SPEED);
    localparam logic [SPEED_W-1:0] SPD_MIN   = SPEED_W'(MIN_SPEED);
    localparam logic [SPEED_W-1:0] SPD_MAX   = SPEED_W'(MAX_SPEED);
    localparam logic [ID_W-1:0]    ID_LAST   = ID_W'(NUM_REQ - 1);

`ifdef DIV_ARB_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic               grant_valid_q, grant_valid_d;
    logic [SPEED_W-1:0] div_speed_q, div_speed_d;
    logic               div_reset_q, div_reset_d;
    logic               busy_q, busy_d;

    logic [SPEED_W-1:0] req_speed [NUM_REQ];
    logic               found;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    winner_nxt;
    logic [IX_W-1:0]    idx;
    logic [SPEED_W-1:0] raw_speed;
    logic [SPEED_W-1:0] eff_speed;
    logic [NUM_REQ-1:0] winner_oh;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_speed[i] = bus.reqSpeed[i*SPEED_W +: SPEED_W];
        end
    end

    // First asserted request scanning upward from rr_ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IX_W'(rr_ptr_q) + IX_W'(k);
            if (idx >= IX_W'(NUM_REQ)) begin
                idx = idx - IX_W'(NUM_REQ);
            end
            if (!found && bus.req[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

    assign winner_nxt = (winner == ID_LAST) ? '0 : winner + 1'b1;
    assign winner_oh  = NUM_REQ'(1) << winner;

    // Zero bypasses the clamp so it is still rejected.
    always_comb begin
        raw_speed = req_speed[winner];
        eff_speed = raw_speed;
        if (CLAMP_EN && (raw_speed != '0)) begin
            if (raw_speed < SPD_MIN) begin
                eff_speed = SPD_MIN;
            end else if (raw_speed > SPD_MAX) begin
                eff_speed = SPD_MAX;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        hold_cnt_d    = hold_cnt_q;
        ack_d         = '0;
        err_d         = '0;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        div_speed_d   = div_speed_q;
        div_reset_d   = 1'b0;
        busy_d        = busy_q;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (found) begin
                    rr_ptr_d = winner_nxt;
                    if (eff_speed == '0) begin
                        err_d = winner_oh;
                    end else if (eff_speed == div_speed_q) begin
                        ack_d         = winner_oh;
                        grant_id_d    = winner;
                        grant_valid_d = 1'b1;
                    end else begin
                        ack_d         = winner_oh;
                        grant_id_d    = winner;
                        grant_valid_d = 1'b1;
                        div_speed_d   = eff_speed;
                        div_reset_d   = 1'b1;
                        busy_d        = 1'b1;
                        state_d       = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                hold_cnt_d = '0;
                busy_d     = 1'b1;
                state_d    = S_HOLD;
            end
            S_HOLD: begin
                busy_d = 1'b1;
                if (hold_cnt_q == HOLD_LAST) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge inClock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            hold_cnt_q    <= '0;
            ack_q         <= '0;
            err_q         <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            div_speed_q   <= SPD_RST;
            div_reset_q   <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            ack_q         <= ack_d;
            err_q         <= err_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            div_speed_q   <= div_speed_d;
            div_reset_q   <= div_reset_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.err        = err_q;
    assign bus.grantId    = grant_id_q;
    assign bus.grantValid = grant_valid_q;
    assign bus.divSpeed   = div_speed_q;
    assign bus.divReset   = div_reset_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_divider_speed_arbiter.sv
// Bench for divider_speed_arbiter: vector table, directed multi-cycle sequences,
// and randomized traffic against a timestamp-based reference model.
module tb_divider_speed_arbiter;
    localparam int NR   = 4;
    localparam int SW   = 20;
    localparam int H    = 1024;
    localparam int DEF  = 1000;
    localparam int MINS = 1;
    localparam int MAXS = 1000000;
    localparam int NV   = 9;

    logic inClock;
    logic reset;
    logic [NR-1:0]    req_v;
    logic [NR*SW-1:0] spk;
    int checks;
    int failures;
    int cyc;

    divider_speed_arbiter_if #(.NUM_REQ(NR), .SPEED_W(SW)) bus ();

    divider_speed_arbiter #(
        .NUM_REQ(NR), .SPEED_W(SW), .HOLD_CYCLES(H),
        .DEFAULT_SPEED(DEF), .MIN_SPEED(MINS), .MAX_SPEED(MAXS)
    ) dut (
        .inClock(inClock),
        .reset(reset),
        .bus(bus)
    );

    assign bus.req      = req_v;
    assign bus.reqSpeed = spk;

    initial inClock = 1'b0;
    always #5 inClock = ~inClock;

    typedef struct {
        logic [NR-1:0]    req;
        logic [NR*SW-1:0] sp;
        logic [32:0]      ex;
    } vec_t;

    vec_t vt [NV];

    logic [SW-1:0]  m_spd;
    logic [1:0]     m_gid;
    logic           m_gv;
    int             m_rr;
    int             m_next_ok;
    int             m_last;
    logic [NR-1:0]  e_ack;
    logic [NR-1:0]  e_err;
    logic           e_drst;
    logic           e_busy;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [32:0] outs();
        return {bus.ack, bus.err, bus.divReset, bus.busy,
                bus.grantValid, bus.grantId, bus.divSpeed};
    endfunction

    function automatic logic [32:0] pk(logic [3:0] a, logic [3:0] e, logic d,
                                       logic b, logic g, logic [1:0] id,
                                       logic [19:0] s);
        return {a, e, d, b, g, id, s};
    endfunction

    function automatic logic [SW-1:0] eff(logic [SW-1:0] s);
`ifdef DIV_ARB_CLAMP_EN
        if (s == '0) return s;
        if (s < SW'(MINS)) return SW'(MINS);
        if (s > SW'(MAXS)) return SW'(MAXS);
`endif
        return s;
    endfunction

    task automatic tick();
        @(posedge inClock);
        cyc++;
        #1;
    endtask

    // Reference: n is the edge index; a load at edge L makes busy true for
    // edges L..L+H and the next decision possible at edge L+H+2.
    task automatic model_step(int n, logic rst, logic [NR-1:0] rq,
                              logic [NR*SW-1:0] sp);
        if (rst) begin
            m_spd = SW'(DEF); m_rr = 0; m_gid = '0; m_gv = 1'b0;
            m_next_ok = n + 1; m_last = -100000;
            e_ack = '0; e_err = '0; e_drst = 1'b1; e_busy = 1'b0;
            return;
        end
        e_ack = '0; e_err = '0; e_drst = 1'b0;
        if (n >= m_next_ok && rq != '0) begin
            int w;
            logic [SW-1:0] s;
            w = -1;
            for (int k = 0; k < NR; k++) begin
                if (w < 0 && rq[(m_rr + k) % NR]) w = (m_rr + k) % NR;
            end
            m_rr = (w + 1) % NR;
            s = eff(sp[w*SW +: SW]);
            if (s == '0) begin
                e_err[w] = 1'b1;
            end else begin
                e_ack[w] = 1'b1;
                m_gid = 2'(w);
                m_gv = 1'b1;
                if (s != m_spd) begin
                    m_spd = s;
                    e_drst = 1'b1;
                    m_last = n;
                    m_next_ok = n + H + 2;
                end
            end
        end
        e_busy = (n >= m_last) && (n - m_last <= H);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SW-1:0] v6s;
        int bc;
        int last;
        bit got;
        checks = 0; failures = 0; cyc = 0;
        reset = 1'b1; req_v = '0; spk = '0;
`ifdef DIV_ARB_CLAMP_EN
        v6s = SW'(MAXS);
`else
        v6s = 20'hFFFFF;
`endif
        vt[0] = '{4'b0010, {20'd0, 20'd0, 20'd44100, 20'd0},
                  pk(4'b0010, 4'b0, 1, 1, 1, 2'd1, 20'd44100)};
        vt[1] = '{4'b0100, {20'd5, 20'd0, 20'd5, 20'd5},
                  pk(4'b0, 4'b0100, 0, 0, 0, 2'd0, 20'd1000)};
        vt[2] = '{4'b1000, {20'd1000, 20'd0, 20'd0, 20'd0},
                  pk(4'b1000, 4'b0, 0, 0, 1, 2'd3, 20'd1000)};
        vt[3] = '{4'b1111, {20'd44, 20'd33, 20'd22, 20'd11},
                  pk(4'b0001, 4'b0, 1, 1, 1, 2'd0, 20'd11)};
        vt[4] = '{4'b1100, {20'd9, 20'd7, 20'd0, 20'd0},
                  pk(4'b0100, 4'b0, 1, 1, 1, 2'd2, 20'd7)};
        vt[5] = '{4'b0000, {20'd1, 20'd2, 20'd3, 20'd4},
                  pk(4'b0, 4'b0, 0, 0, 0, 2'd0, 20'd1000)};
        vt[6] = '{4'b1000, {20'hFFFFF, 20'd0, 20'd0, 20'd0},
                  pk(4'b1000, 4'b0, 1, 1, 1, 2'd3, v6s)};
        vt[7] = '{4'b0011, {20'd0, 20'd0, 20'd5, 20'd0},
                  pk(4'b0, 4'b0001, 0, 0, 0, 2'd0, 20'd1000)};
        vt[8] = '{4'b0001, {20'd0, 20'd0, 20'd0, 20'd1},
                  pk(4'b0001, 4'b0, 1, 1, 1, 2'd0, 20'd1)};

        // Reset behaviour
        repeat (3) tick();
        chk("rst_outs", 64'(outs()), 64'(pk(0, 0, 1, 0, 0, 0, 20'd1000)));
        reset = 1'b0;
        tick();
        chk("post_rst_divReset", 64'(bus.divReset), 64'd0);
        chk("post_rst_speed", 64'(bus.divSpeed), 64'd1000);

        // Single decisions from the reset state
        for (int v = 0; v < NV; v++) begin
            reset = 1'b1; req_v = '0;
            tick();
            req_v = vt[v].req; spk = vt[v].sp; reset = 1'b0;
            tick();
            chk($sformatf("vec%0d", v), 64'(outs()), 64'(vt[v].ex));
            req_v = '0;
        end

        // Busy window after a load
        reset = 1'b1; tick(); reset = 1'b0; tick();
        req_v = 4'b0010; spk = {20'd0, 20'd0, 20'd44100, 20'd0};
        tick();
        chk("t2_ack", 64'({bus.ack, bus.divReset, bus.divSpeed}),
            64'({4'b0010, 1'b1, 20'd44100}));
        req_v = '0;
        tick();
        chk("t2_drst_fall", 64'({bus.divReset, bus.busy}), 64'({1'b0, 1'b1}));
        bc = 2;
        for (int k = 0; k < H + 10; k++) begin
            tick();
            if (!bus.busy) break;
            bc++;
        end
        chk("t2_busy_len", 64'(bc), 64'(H + 1));

        // Reject advances the pointer; equal speed acks without a load
        reset = 1'b1; tick(); reset = 1'b0; tick();
        req_v = 4'b0100; spk = '0;
        tick();
        chk("t4_err", 64'({bus.ack, bus.err, bus.divReset, bus.divSpeed}),
            64'({4'b0, 4'b0100, 1'b0, 20'd1000}));
        req_v = 4'b1011; spk = {20'd1000, 20'd0, 20'd6, 20'd5};
        tick();
        chk("t4_equal", 64'({bus.ack, bus.err, bus.divReset, bus.busy,
                            bus.grantValid, bus.grantId}),
            64'({4'b1000, 4'b0, 1'b0, 1'b0, 1'b1, 2'd3}));
        req_v = '0;

        // All requesters held: rotation and divReset spacing
        reset = 1'b1; tick(); reset = 1'b0; tick();
        req_v = 4'b1111; spk = {20'd400, 20'd300, 20'd200, 20'd100};
        last = -1;
        for (int g = 0; g < 5; g++) begin
            got = 1'b0;
            for (int k = 0; k < H + 10; k++) begin
                tick();
                if (bus.divReset) begin
                    got = 1'b1;
                    break;
                end
            end
            chk($sformatf("t3_pulse%0d", g), 64'(got), 64'd1);
            chk($sformatf("t3_grant%0d", g), 64'(bus.grantId), 64'(g % NR));
            if (last >= 0) chk($sformatf("t3_space%0d", g), 64'(cyc - last), 64'(H + 2));
            last = cyc;
        end
        req_v = '0;

        // Reset in the middle of the dwell
        reset = 1'b1; tick(); reset = 1'b0; tick();
        req_v = 4'b0100; spk = {20'd0, 20'd500, 20'd0, 20'd0};
        tick();
        chk("t5_load", 64'(bus.ack), 64'(4'b0100));
        req_v = 4'b1010; spk = {20'd333, 20'd500, 20'd111, 20'd0};
        repeat (501) tick();
        chk("t5_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        tick();
        chk("t5_abort", 64'({bus.ack, bus.divReset, bus.busy,
                            bus.grantValid, bus.divSpeed}),
            64'({4'b0, 1'b1, 1'b0, 1'b0, 20'd1000}));
        reset = 1'b0;
        tick();
        chk("t5_regrant", 64'({bus.ack, bus.grantId, bus.divSpeed}),
            64'({4'b0010, 2'd1, 20'd111}));
        req_v = '0;

        // Randomized traffic with occasional resets
        for (int c = 0; c < 24000; c++) begin
            reset = (c < 2) ? 1'b1 : ($urandom_range(0, 2999) == 0);
            model_step(cyc + 1, reset, req_v, spk);
            tick();
            chk($sformatf("rand_c%0d", c), 64'(outs()),
                64'({e_ack, e_err, e_drst, e_busy, m_gv, m_gid, m_spd}));
            for (int i = 0; i < NR; i++) begin
                if (bus.ack[i] || bus.err[i]) begin
                    req_v[i] = 1'b0;
                end else if (req_v[i]) begin
                    if ($urandom_range(0, 199) == 0) req_v[i] = 1'b0;
                end else if ($urandom_range(0, 29) == 0) begin
                    int r;
                    logic [SW-1:0] s;
                    r = int'($urandom_range(0, 9));
                    if (r == 0) s = '0;
                    else if (r <= 2) s = m_spd;
                    else if (r == 3) s = 20'hFFFFF;
                    else s = SW'($urandom_range(1, 20'hFFFFF));
                    spk[i*SW +: SW] = s;
                    req_v[i] = 1'b1;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
